mips_seq_ctrl: RTL and testbench
================================

# mips_seq_ctrl

Multi-cycle instruction sequencer for the MIPS core. It steps each instruction through fetch, decode, execute, memory, writeback and PC update. It drives the edge-triggered PC update unit through a setup/start/finish handshake, and it issues the one-time PC clear after reset. It sits between the instruction/data memory ports, the register file write enable and the PC unit.

## Interface
- `TIMEOUT_CYCLES`, default 15: maximum wait cycles in any handshake state. Used only with `SEQ_TIMEOUT_EN`.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level signal; 1 means sequence instructions continuously.
- `step`  in  1  one-cycle pulse; executes one instruction when idle and `run=0`.
- `opcode`  in  6  instruction register bits [31:26]; valid from the cycle after `ir_load`.
- `alu_zero`  in  1  ALU zero flag; valid in EXEC.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  fetch complete.
- `ir_load`  out  1  `imem_req & imem_ack`; latches the instruction register.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  store qualifier; valid only with `dmem_req`.
- `dmem_ack`  in  1  data access complete.
- `rf_we`  out  1  register file write, one-cycle pulse.
- `pc_reset`  out  1  drives the PC unit `reset` input.
- `pc_jump`  out  1  drives the PC unit `jump` input.
- `pc_beq`  out  1  drives the PC unit `beq` input (branch taken).
- `pc_start`  out  1  drives the PC unit `start` input; high for exactly one cycle.
- `pc_finish`  in  1  PC unit `finish`.
- `state`  out  4  current state encoding.
- `busy`  out  1  `state != IDLE`.
- `instr_count`  out  32  count of retired instructions.
- `error`  out  1  sticky handshake timeout flag.

## Operation
- State encodings: RST_PC=0, IDLE=1, FETCH=2, DECODE=3, EXEC=4, MEM=5, WB=6, PC_SET=7, PC_GO=8, PC_WAIT=9. All outputs are registered except `ir_load` and `busy`.
- While `reset_n` is low:
  - state=RST_PC and `pc_reset`=1.
  - All other outputs are 0, except `busy`=1.
  - An internal `rst_pend` flag is set.
- RST_PC → PC_SET unconditionally.
- PC sequence:
  - PC_SET: `pc_jump`, `pc_beq` and `pc_reset` are stable and `pc_start`=0.
  - PC_GO: `pc_start`=1 for this cycle only.
  - PC_WAIT: `pc_start`=0; the state exits when `pc_finish`=1.
  - The three control lines hold from PC_SET entry until PC_WAIT exit, then clear to 0.
- PC_WAIT exit:
  - If `rst_pend`=1: clear `rst_pend` and `pc_reset`, go to IDLE. No count.
  - Otherwise: `instr_count`+1 (wraps 0xFFFFFFFF→0), then FETCH if `run`=1, else IDLE.
- IDLE → FETCH when `run`=1, or when `step`=1. `step` is ignored outside IDLE.
- FETCH: `imem_req`=1 until `imem_ack`, then go to DECODE.
- DECODE dispatch on `opcode`:
  - 000000 (R-type), 001000 (addi), 100011 (lw), 101011 (sw), 000100 (beq): go to EXEC.
  - 000010 (j): set `pc_jump`, go to PC_SET.
  - Any other value: treated as a NOP, go to PC_SET.
- EXEC takes one cycle:
  - beq: `pc_beq` ← `alu_zero`, then PC_SET.
  - lw/sw: go to MEM.
  - R-type/addi: go to WB.
- MEM: `dmem_req`=1 (`dmem_we`=1 for sw) until `dmem_ack`. lw then goes to WB; sw goes to PC_SET.
- WB: `rf_we`=1 for one cycle, then PC_SET.
- Asserting `reset_n` low mid-instruction aborts immediately. There is no retire and no count. The reset PC sequence repeats.

## Timing
- Cycles from FETCH entry to retire (PC_WAIT exit), with zero-wait acks and `pc_finish` high:
  - R-type and addi: 7.
  - lw: 8.
  - sw: 7.
  - beq: 6.
  - j: 5.
  - NOP: 5.
- The reset sequence takes 4 cycles from `reset_n` rising to IDLE: RST_PC, PC_SET, PC_GO, PC_WAIT.
- `pc_start` never rises in the same cycle that `pc_jump`, `pc_beq` or `pc_reset` changes.
- Handshake waits are unbounded in the base build.

## Configuration
- Macro `SEQ_TIMEOUT_EN`.
  - Defined: a wait counter runs in FETCH, MEM and PC_WAIT. If the ack or finish is still missing after `TIMEOUT_CYCLES` cycles, the block:
    - sets `error`;
    - drops all requests;
    - goes to IDLE;
    - ignores `run` and `step` until `reset_n` is asserted.
  - Not defined: no counter, `error` is tied to 0, and the parameter is unused.

## Test plan
- Reset release with `pc_finish`=1 → states 0,7,8,9,1. `pc_reset`=1 through PC_WAIT, one `pc_start` pulse in PC_GO, `instr_count`=0.
- `run`=1, opcode 000000, acks immediate → 7 cycles per retire, one `rf_we` pulse each, `instr_count` 1,2,3.
- lw with `dmem_ack` delayed 3 cycles → `dmem_req` high for 4 cycles with `dmem_we`=0, then WB, then retire.
- beq with `alu_zero`=1, then with `alu_zero`=0 → `pc_beq`=1 and 0 respectively during PC_SET..PC_WAIT. Opcode 000010 gives `pc_jump`=1 and a 5-cycle retire.
- `run`=0, `step` pulses in IDLE → exactly one instruction retires, back to IDLE. A `step` during FETCH is ignored.
- With `SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=15: hold `imem_ack`=0 → `error`=1 after 15 FETCH cycles, state IDLE, `run`=1 has no effect until `reset_n` is pulsed.

Source files
------------

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle MIPS instruction sequencer with PC-unit setup/start/finish handshake.
// Optional handshake watchdog is compiled in when SEQ_TIMEOUT_EN is defined.
module mips_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        step,
    input  logic [5:0]  opcode,
    input  logic        alu_zero,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_load,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic        pc_reset,
    output logic        pc_jump,
    output logic        pc_beq,
    output logic        pc_start,
    input  logic        pc_finish,
    output logic [3:0]  state,
    output logic        busy,
    output logic [31:0] instr_count,
    output logic        error
);

    typedef enum logic [3:0] {
        ST_RST_PC  = 4'd0,
        ST_IDLE    = 4'd1,
        ST_FETCH   = 4'd2,
        ST_DECODE  = 4'd3,
        ST_EXEC    = 4'd4,
        ST_MEM     = 4'd5,
        ST_WB      = 4'd6,
        ST_PC_SET  = 4'd7,
        ST_PC_GO   = 4'd8,
        ST_PC_WAIT = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        OP_ALU,
        OP_LW,
        OP_SW,
        OP_BEQ
    } op_class_t;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;

    state_t      state_q;
    op_class_t   op_q;
    logic        rst_pend_q;
    logic        imem_req_q;
    logic        dmem_req_q;
    logic        dmem_we_q;
    logic        rf_we_q;
    logic        pc_reset_q;
    logic        pc_jump_q;
    logic        pc_beq_q;
    logic        pc_start_q;
    logic [31:0] instr_count_q;
    logic        error_q;
    logic        timeout;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt_q;
    logic              in_wait;
    logic              wait_done;

    always_comb begin
        in_wait   = (state_q == ST_FETCH) || (state_q == ST_MEM) || (state_q == ST_PC_WAIT);
        wait_done = ((state_q == ST_FETCH)   && imem_ack)
                 || ((state_q == ST_MEM)     && dmem_ack)
                 || ((state_q == ST_PC_WAIT) && pc_finish);
        timeout   = in_wait && !wait_done && (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));
    end

    // Counts completed wait cycles of the current handshake; restarts on every ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
        end else if (!in_wait || wait_done || timeout) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // NOTE: registered outputs are assigned on the transition into the state
    // they belong to, so they line up with state_q in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RST_PC;
            op_q          <= OP_ALU;
            rst_pend_q    <= 1'b1;
            imem_req_q    <= 1'b0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            rf_we_q       <= 1'b0;
            pc_reset_q    <= 1'b1;
            pc_jump_q     <= 1'b0;
            pc_beq_q      <= 1'b0;
            pc_start_q    <= 1'b0;
            instr_count_q <= '0;
            error_q       <= 1'b0;
        end else if (timeout) begin
            state_q    <= ST_IDLE;
            error_q    <= 1'b1;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            pc_reset_q <= 1'b0;
            pc_jump_q  <= 1'b0;
            pc_beq_q   <= 1'b0;
            pc_start_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_RST_PC: state_q <= ST_PC_SET;
                ST_IDLE: begin
                    if (!error_q && (run || step)) begin
                        state_q    <= ST_FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        state_q    <= ST_DECODE;
                        imem_req_q <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    case (opcode)
                        OPC_RTYPE, OPC_ADDI: begin op_q <= OP_ALU; state_q <= ST_EXEC; end
                        OPC_LW:              begin op_q <= OP_LW;  state_q <= ST_EXEC; end
                        OPC_SW:              begin op_q <= OP_SW;  state_q <= ST_EXEC; end
                        OPC_BEQ:             begin op_q <= OP_BEQ; state_q <= ST_EXEC; end
                        OPC_J: begin
                            pc_jump_q <= 1'b1;
                            state_q   <= ST_PC_SET;
                        end
                        default:             state_q <= ST_PC_SET;
                    endcase
                end
                ST_EXEC: begin
                    unique case (op_q)
                        OP_BEQ: begin
                            pc_beq_q <= alu_zero;
                            state_q  <= ST_PC_SET;
                        end
                        OP_LW, OP_SW: begin
                            dmem_req_q <= 1'b1;
                            dmem_we_q  <= (op_q == OP_SW);
                            state_q    <= ST_MEM;
                        end
                        default: begin
                            rf_we_q <= 1'b1;
                            state_q <= ST_WB;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        rf_we_q    <= (op_q == OP_LW);
                        state_q    <= (op_q == OP_LW) ? ST_WB : ST_PC_SET;
                    end
                end
                ST_WB: begin
                    rf_we_q <= 1'b0;
                    state_q <= ST_PC_SET;
                end
                ST_PC_SET: begin
                    pc_start_q <= 1'b1;
                    state_q    <= ST_PC_GO;
                end
                ST_PC_GO: begin
                    pc_start_q <= 1'b0;
                    state_q    <= ST_PC_WAIT;
                end
                ST_PC_WAIT: begin
                    if (pc_finish) begin
                        pc_reset_q <= 1'b0;
                        pc_jump_q  <= 1'b0;
                        pc_beq_q   <= 1'b0;
                        if (rst_pend_q) begin
                            rst_pend_q <= 1'b0;
                            state_q    <= ST_IDLE;
                        end else begin
                            instr_count_q <= instr_count_q + 32'd1;
                            if (run) begin
                                imem_req_q <= 1'b1;
                                state_q    <= ST_FETCH;
                            end else begin
                                state_q    <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign state       = state_q;
    assign busy        = (state_q != ST_IDLE);
    assign ir_load     = imem_req_q & imem_ack;
    assign imem_req    = imem_req_q;
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign rf_we       = rf_we_q;
    assign pc_reset    = pc_reset_q;
    assign pc_jump     = pc_jump_q;
    assign pc_beq      = pc_beq_q;
    assign pc_start    = pc_start_q;
    assign instr_count = instr_count_q;
    assign error       = error_q;

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Self-checking bench for mips_seq_ctrl: directed and randomized instructions
// compared against a latency/effect model derived from the instruction classes.
module tb_mips_seq_ctrl;

    localparam int unsigned TO_CYCLES = 15;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;

    localparam logic [3:0] S_RST_PC  = 4'd0;
    localparam logic [3:0] S_IDLE    = 4'd1;
    localparam logic [3:0] S_FETCH   = 4'd2;
    localparam logic [3:0] S_MEM     = 4'd5;
    localparam logic [3:0] S_PC_SET  = 4'd7;
    localparam logic [3:0] S_PC_GO   = 4'd8;
    localparam logic [3:0] S_PC_WAIT = 4'd9;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run, step, alu_zero;
    logic [5:0]  opcode;
    logic        imem_req, imem_ack, ir_load;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        rf_we, pc_reset, pc_jump, pc_beq, pc_start, pc_finish;
    logic [3:0]  state;
    logic        busy, error;
    logic [31:0] instr_count;

    int          n_vec;
    int          n_err;
    logic [31:0] exp_count;

    mips_seq_ctrl #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .step        (step),
        .opcode      (opcode),
        .alu_zero    (alu_zero),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .ir_load     (ir_load),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .rf_we       (rf_we),
        .pc_reset    (pc_reset),
        .pc_jump     (pc_jump),
        .pc_beq      (pc_beq),
        .pc_start    (pc_start),
        .pc_finish   (pc_finish),
        .state       (state),
        .busy        (busy),
        .instr_count (instr_count),
        .error       (error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: cycles from FETCH entry to retire for each instruction class.
    function automatic int exp_latency(input logic [5:0] op, input int iw, input int dw, input int fw);
        case (op)
            OPC_RTYPE, OPC_ADDI: return 7 + iw + fw;
            OPC_LW:              return 8 + iw + dw + fw;
            OPC_SW:              return 7 + iw + dw + fw;
            OPC_BEQ:             return 6 + iw + fw;
            default:             return 5 + iw + fw;
        endcase
    endfunction

    function automatic bit is_mem(input logic [5:0] op);
        return (op == OPC_LW) || (op == OPC_SW);
    endfunction

    function automatic bit writes_rf(input logic [5:0] op);
        return (op == OPC_RTYPE) || (op == OPC_ADDI) || (op == OPC_LW);
    endfunction

    // Releases reset and follows the PC-clear sequence back to IDLE.
    task automatic reset_release();
        logic [3:0] exp_st [5];
        exp_st = '{S_RST_PC, S_PC_SET, S_PC_GO, S_PC_WAIT, S_IDLE};
        pc_finish = 1'b1;
        reset_n   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("rstseq_state[%0d]", i), 32'(state), 32'(exp_st[i]));
            check($sformatf("rstseq_pc_reset[%0d]", i), 32'(pc_reset), 32'(i < 4));
            check($sformatf("rstseq_pc_start[%0d]", i), 32'(pc_start), 32'(i == 2));
        end
        check("rstseq_count", instr_count, 32'd0);
        exp_count = 32'd0;
    endtask

    // Issues one instruction from IDLE with run=0 via a step pulse, with
    // iw/dw/fw extra wait cycles on fetch ack, data ack and pc_finish.
    task automatic do_instr(input logic [5:0] op, input logic az, input int iw, input int dw,
                            input int fw, input bit step_in_fetch);
        int   lat, rfw, dreq, dwe, starts, unstable, fc, mc, wc;
        logic saw_j, saw_b, saw_r;
        logic [2:0] prev_lines;
        lat = 0; rfw = 0; dreq = 0; dwe = 0; starts = 0; unstable = 0;
        fc = 0; mc = 0; wc = 0;
        saw_j = 1'b0; saw_b = 1'b0; saw_r = 1'b0; prev_lines = 3'b000;
        opcode   = op;
        alu_zero = az;
        step     = 1'b1;
        @(negedge clk);
        step = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (state == S_IDLE) break;
            lat++;
            if (rf_we) rfw++;
            if (dmem_req) dreq++;
            if (dmem_we) dwe++;
            if (pc_start) begin
                starts++;
                if ({pc_jump, pc_beq, pc_reset} !== prev_lines) unstable++;
            end
            prev_lines = {pc_jump, pc_beq, pc_reset};
            if (state == S_PC_WAIT) begin
                saw_j = pc_jump; saw_b = pc_beq; saw_r = pc_reset;
            end
            step      = step_in_fetch && (state == S_FETCH) && (fc == 1);
            imem_ack  = (state == S_FETCH) && (fc >= iw);
            dmem_ack  = (state == S_MEM) && (mc >= dw);
            pc_finish = !((state == S_PC_WAIT) && (wc < fw));
            if (state == S_FETCH) fc++;
            if (state == S_MEM) mc++;
            if (state == S_PC_WAIT) wc++;
            @(negedge clk);
        end
        step = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; pc_finish = 1'b1;
        check($sformatf("op%06b_done", op), 32'(state), 32'(S_IDLE));
        check($sformatf("op%06b_latency", op), 32'(lat), 32'(exp_latency(op, iw, dw, fw)));
        check($sformatf("op%06b_rf_we", op), 32'(rfw), 32'(writes_rf(op)));
        check($sformatf("op%06b_dmem_req", op), 32'(dreq), is_mem(op) ? 32'(dw + 1) : 32'd0);
        check($sformatf("op%06b_dmem_we", op), 32'(dwe), (op == OPC_SW) ? 32'(dw + 1) : 32'd0);
        check($sformatf("op%06b_pc_lines", op), 32'({saw_j, saw_b, saw_r}),
              32'({op == OPC_J, (op == OPC_BEQ) && az, 1'b0}));
        check($sformatf("op%06b_pc_start", op), 32'(starts), 32'd1);
        check($sformatf("op%06b_start_stable", op), 32'(unstable), 32'd0);
        check($sformatf("op%06b_error", op), 32'(error), 32'd0);
        exp_count = exp_count + 32'd1;
        check($sformatf("op%06b_count", op), instr_count, exp_count);
        if (step_in_fetch) begin
            @(negedge clk);
            check("step_in_fetch_idle", 32'(state), 32'(S_IDLE));
        end
    endtask

    initial begin
        logic [5:0] valid_ops [6];
        logic [5:0] op;
        int         pick, rfw, nfetch;
        valid_ops = '{OPC_RTYPE, OPC_ADDI, OPC_LW, OPC_SW, OPC_BEQ, OPC_J};
        n_vec = 0; n_err = 0; exp_count = 32'd0;
        reset_n = 1'b0; run = 1'b0; step = 1'b0; opcode = 6'd0; alu_zero = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; pc_finish = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'(S_RST_PC));
        check("rst_pc_reset", 32'(pc_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_outputs", 32'({imem_req, ir_load, dmem_req, dmem_we, rf_we,
                                  pc_jump, pc_beq, pc_start, error}), 32'd0);
        check("rst_count", instr_count, 32'd0);
        reset_release();

        // Continuous run of R-type instructions with immediate acks.
        imem_ack = 1'b1; opcode = OPC_RTYPE; run = 1'b1; rfw = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 1) check("run_first_fetch", 32'(state), 32'(S_FETCH));
            if (k <= 21 && rf_we) rfw++;
            if (k == 7 || k == 8 || k == 15 || k == 22)
                check($sformatf("run_count_k%0d", k), instr_count, exp_count + 32'((k - 1) / 7));
            if (k == 15) run = 1'b0;
        end
        check("run_rf_we_pulses", 32'(rfw), 32'd3);
        check("run_end_idle", 32'(state), 32'(S_IDLE));
        imem_ack  = 1'b0;
        exp_count = exp_count + 32'd3;

        do_instr(OPC_LW,    1'b0, 0, 3, 0, 1'b0);
        do_instr(OPC_BEQ,   1'b1, 0, 0, 0, 1'b0);
        do_instr(OPC_BEQ,   1'b0, 0, 0, 0, 1'b0);
        do_instr(OPC_J,     1'b0, 0, 0, 0, 1'b0);
        do_instr(6'b111111, 1'b0, 0, 0, 0, 1'b0);
        do_instr(OPC_SW,    1'b1, 1, 2, 1, 1'b0);
        do_instr(OPC_ADDI,  1'b0, 2, 0, 0, 1'b1);
`ifndef SEQ_TIMEOUT_EN
        do_instr(OPC_SW,    1'b0, 20, 2, 1, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            pick = int'($urandom_range(0, 6));
            if (pick < 6) begin
                op = valid_ops[pick];
            end else begin
                op = 6'($urandom);
                while (op == OPC_RTYPE || op == OPC_ADDI || op == OPC_LW ||
                       op == OPC_SW || op == OPC_BEQ || op == OPC_J)
                    op = 6'($urandom);
            end
            do_instr(op, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)), 1'b0);
        end

        // Reset in the middle of a load aborts with no retire.
        opcode = OPC_LW; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (state == S_MEM) break;
            imem_ack = (state == S_FETCH);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        check("abort_reached_mem", 32'(state), 32'(S_MEM));
        reset_n = 1'b0;
        #1;
        check("abort_state", 32'(state), 32'(S_RST_PC));
        check("abort_outputs", 32'({dmem_req, rf_we, pc_reset}), 32'b001);
        @(negedge clk);
        reset_release();

`ifdef SEQ_TIMEOUT_EN
        // Fetch ack never arrives: watchdog fires and locks out run.
        imem_ack = 1'b0; run = 1'b1; nfetch = 0;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (state != S_FETCH) break;
            nfetch++;
            @(negedge clk);
        end
        check("to_fetch_cycles", 32'(nfetch), 32'(TO_CYCLES));
        check("to_state", 32'(state), 32'(S_IDLE));
        check("to_error", 32'(error), 32'd1);
        check("to_imem_req", 32'(imem_req), 32'd0);
        repeat (5) @(negedge clk);
        check("to_locked", 32'(state), 32'(S_IDLE));
        run = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_release();
        check("to_error_cleared", 32'(error), 32'd0);
`else
        nfetch = 0;
        check("no_timeout_error", 32'(error), 32'(nfetch));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
